// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 16-bit ALU and its NVZ flag register between the CPU
// execute stage (port C) and the NN accelerator (port N). One op is in flight
// at a time; only CPU ops are allowed to update the flags.
// Optional feature: define ALU_ARB_STARVE_GUARD_EN to let N win after
// STARVE_MAX consecutive C grants taken while N was waiting.
module alu_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ALU_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic [3:0]        c_op,
    input  logic [DATA_W-1:0] c_a,
    input  logic [DATA_W-1:0] c_b,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_res,
    output logic              c_ovfl,
    input  logic              n_req,
    input  logic [3:0]        n_op,
    input  logic [DATA_W-1:0] n_a,
    input  logic [DATA_W-1:0] n_b,
    output logic              n_gnt,
    output logic              n_done,
    output logic [DATA_W-1:0] n_res,
    output logic              n_ovfl,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ovfl,
    output logic              flag_dis,
    output logic              busy
);

    // Out-of-range configurations fall back to single-cycle latency.
    localparam bit PARAM_OK = (ALU_LAT >= 1) && (ALU_LAT <= 8) &&
                              (STARVE_MAX >= 1) && (STARVE_MAX <= 15);
    localparam logic [3:0] LAT_LD = PARAM_OK ? 4'(ALU_LAT) : 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] count;
    logic       owner_n;   // 1 when the op in flight belongs to port N
    logic       n_win;

`ifdef ALU_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve;

    // N wins when C is idle, or once C has been served STARVE_MAX times in a row while N waited.
    always_comb begin
        n_win = n_req && (!c_req || (starve == STARVE_LIM));
    end
`else
    // Strict CPU priority: N is served only when C is not requesting.
    always_comb begin
        n_win = n_req && !c_req;
    end
`endif

    // Grants are combinational from the requests so the requester sees acceptance in the same cycle.
    always_comb begin
        c_gnt = (state == IDLE) && c_req && !n_win;
        n_gnt = (state == IDLE) && n_win;
    end

    // Arbitration FSM: issue, wait out the ALU latency, capture, then report done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            owner_n  <= 1'b0;
            alu_op   <= 4'd0;
            alu_a    <= '0;
            alu_b    <= '0;
            c_res    <= '0;
            c_ovfl   <= 1'b0;
            n_res    <= '0;
            n_ovfl   <= 1'b0;
            c_done   <= 1'b0;
            n_done   <= 1'b0;
            flag_dis <= 1'b1;
            busy     <= 1'b0;
`ifdef ALU_ARB_STARVE_GUARD_EN
            starve   <= 4'd0;
`endif
        end else begin
            c_done   <= 1'b0;
            n_done   <= 1'b0;
            flag_dis <= 1'b1;
            case (state)
                IDLE: begin
                    if (c_gnt || n_gnt) begin
                        owner_n <= n_gnt;
                        alu_op  <= n_gnt ? n_op : c_op;
                        alu_a   <= n_gnt ? n_a : c_a;
                        alu_b   <= n_gnt ? n_b : c_b;
                        count   <= LAT_LD;
                        state   <= BUSY;
                        busy    <= 1'b1;
                        // With single-cycle latency the very next cycle is the capture cycle.
                        if (c_gnt && (LAT_LD == 4'd1)) begin
                            flag_dis <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    // Open the flag register for the upcoming capture cycle of a CPU op.
                    if ((count == 4'd2) && !owner_n) begin
                        flag_dis <= 1'b0;
                    end
                    if (count == 4'd1) begin
                        if (owner_n) begin
                            n_res  <= alu_out;
                            n_ovfl <= alu_ovfl;
                        end else begin
                            c_res  <= alu_out;
                            c_ovfl <= alu_ovfl;
                        end
                        c_done <= !owner_n;
                        n_done <= owner_n;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
`ifdef ALU_ARB_STARVE_GUARD_EN
            if (n_gnt) begin
                starve <= 4'd0;
            end else if (c_gnt && n_req) begin
                starve <= starve + 4'd1;
            end else if ((state == IDLE) && !n_req) begin
                starve <= 4'd0;
            end
`endif
        end
    end

endmodule
